// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice: channel map,
// repeat-FSM state encoding and default board timing.
package btn_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_FIRE1 = 2;
    localparam int BTN_FIRE2 = 3;

    // 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_RATE     = 5000000;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button lane: two-flop synchroniser, counter debounce, press/release
// edge pulses and an auto-repeat pulse generator.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_raw,
    output logic btn_n_clean,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_RATE);
    localparam int RC_W    = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE - 1);

    logic            sync_meta_r;
    logic            sync_r;
    logic            stable_r;
    logic            stable_nxt_s;
    logic [DB_W-1:0] db_cnt_r;
    logic [DB_W-1:0] db_cnt_nxt_s;
    logic            clean_r;
    logic            pressed_r;
    logic            press_pulse_r;
    logic            release_pulse_r;
    logic            repeat_pulse_r;
    logic            press_evt_s;
    logic            release_evt_s;
    rpt_state_e      state_r;
    rpt_state_e      state_nxt_s;
    logic [RC_W-1:0] rcnt_r;
    logic [RC_W-1:0] rcnt_nxt_s;
    logic            rpt_fire_s;

    // Two-flop synchroniser; idles at the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_r <= 1'b1;
            sync_r      <= 1'b1;
        end else begin
            sync_meta_r <= btn_n_raw;
            sync_r      <= sync_meta_r;
        end
    end

    // Debounce: any agreeing cycle restarts the disagreement count
    always_comb begin
        stable_nxt_s = stable_r;
        db_cnt_nxt_s = db_cnt_r;
        if (sync_r == stable_r) begin
            db_cnt_nxt_s = {DB_W{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
            stable_nxt_s = sync_r;
            db_cnt_nxt_s = {DB_W{1'b0}};
        end else begin
            db_cnt_nxt_s = db_cnt_r + DB_W'(1'b1);
        end
    end

    // Debounce state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b1;
            db_cnt_r <= {DB_W{1'b0}};
        end else begin
            stable_r <= stable_nxt_s;
            db_cnt_r <= db_cnt_nxt_s;
        end
    end

    // The output stage lags stable_r by one cycle, so a mismatch marks an accepted edge
    assign press_evt_s   = clean_r & ~stable_r;
    assign release_evt_s = ~clean_r & stable_r;

    // Repeat FSM next state; an accepted release overrides any expiry
    always_comb begin
        state_nxt_s = state_r;
        rcnt_nxt_s  = rcnt_r;
        rpt_fire_s  = 1'b0;
        if (release_evt_s) begin
            state_nxt_s = RPT_IDLE;
            rcnt_nxt_s  = {RC_W{1'b0}};
        end else begin
            case (state_r)
                RPT_IDLE: begin
                    if (press_evt_s) begin
                        rpt_fire_s  = 1'b1;
                        rcnt_nxt_s  = {RC_W{1'b0}};
                        state_nxt_s = RPT_DELAY;
                    end else begin
                        rcnt_nxt_s  = {RC_W{1'b0}};
                    end
                end
                RPT_DELAY: begin
                    if (rcnt_r == DELAY_LAST) begin
                        rpt_fire_s  = 1'b1;
                        rcnt_nxt_s  = {RC_W{1'b0}};
                        state_nxt_s = RPT_REPEAT;
                    end else begin
                        rcnt_nxt_s  = rcnt_r + RC_W'(1'b1);
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt_r == RATE_LAST) begin
                        rpt_fire_s = 1'b1;
                        rcnt_nxt_s = {RC_W{1'b0}};
                    end else begin
                        rcnt_nxt_s = rcnt_r + RC_W'(1'b1);
                    end
                end
                default: begin
                    state_nxt_s = RPT_IDLE;
                    rcnt_nxt_s  = {RC_W{1'b0}};
                end
            endcase
        end
    end

    // Repeat FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RPT_IDLE;
            rcnt_r  <= {RC_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
        end
    end

    // Registered outputs: level and pulses change on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_r         <= 1'b1;
            pressed_r       <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
            repeat_pulse_r  <= 1'b0;
        end else begin
            clean_r         <= stable_r;
            pressed_r       <= ~stable_r;
            press_pulse_r   <= press_evt_s;
            release_pulse_r <= release_evt_s;
            repeat_pulse_r  <= rpt_fire_s;
        end
    end

    assign btn_n_clean   = clean_r;
    assign pressed       = pressed_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;
    assign repeat_pulse  = repeat_pulse_r;

endmodule

// File: rtl/button_conditioner_checker.sv
// Structural invariants on the conditioned button outputs.
module button_conditioner_checker #(
    parameter int NUM_BTN = 4
) (
    input logic               clk,
    input logic               rst_n,
    input logic [NUM_BTN-1:0] btn_n_clean,
    input logic [NUM_BTN-1:0] pressed,
    input logic [NUM_BTN-1:0] press_pulse,
    input logic [NUM_BTN-1:0] release_pulse,
    input logic [NUM_BTN-1:0] repeat_pulse
);

    a_level_polarity: assert property (@(posedge clk) disable iff (!rst_n)
        pressed == ~btn_n_clean);

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        (press_pulse & release_pulse) == {NUM_BTN{1'b0}});

    a_press_repeats: assert property (@(posedge clk) disable iff (!rst_n)
        (press_pulse & ~repeat_pulse) == {NUM_BTN{1'b0}});

    a_press_level: assert property (@(posedge clk) disable iff (!rst_n)
        (press_pulse & ~pressed) == {NUM_BTN{1'b0}});

    a_release_level: assert property (@(posedge clk) disable iff (!rst_n)
        (release_pulse & pressed) == {NUM_BTN{1'b0}});

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front end: one independent conditioning lane per button,
// outputs concatenated into game-core facing vectors.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_n_raw,
    output logic [NUM_BTN-1:0] btn_n_clean,
    output logic [NUM_BTN-1:0] pressed,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_n_raw     (btn_n_raw[i]),
            .btn_n_clean   (btn_n_clean[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    button_conditioner_checker #(
        .NUM_BTN (NUM_BTN)
    ) u_checker (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n_clean   (btn_n_clean),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

endmodule
